alu_result_capture: RTL and testbench

// - Receive end of the ALU stimulus path: captures each issued {op, i0, i1} with the
//   ALU's o/overflow/cout into a FIFO, and drains records to a reader (checker, UART

---
 rtl/alu_result_capture.sv | 100 ++++++++++
 tb/tb_alu_result_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_capture.sv
// Capture FIFO for ALU stimulus/response records with a valid/ready read port.
// Optional result MISR on `sig` is enabled by defining ALU_CAP_SIGNATURE_EN.
module alu_result_capture #(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cap_valid,
   output logic                         cap_ready,
   input  logic [3:0]                   op,
   input  logic [15:0]                  i0,
   input  logic [15:0]                  i1,
   input  logic [31:0]                  o,
   input  logic                         overflow,
   input  logic                         cout,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [69:0]                  rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [7:0]                   drop_cnt,
   output logic [31:0]                  sig
);

   localparam int REC_W = 70;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic             push, pop;
   logic [REC_W-1:0] cap_rec;

   assign cap_ready = (count_q != CW'(DEPTH));
   assign rd_valid  = (count_q != '0);
   assign push      = cap_valid & cap_ready;
   assign pop       = rd_valid & rd_ready;
   assign cap_rec   = {op, i0, i1, o, overflow, cout};
   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign drop_cnt  = drop_cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (cap_valid && !cap_ready && drop_cnt_q != 8'hFF)
         drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is deliberately left out of reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cap_rec;
   end

`ifdef ALU_CAP_SIGNATURE_EN
   logic [31:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (push)
         sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h04C11DB7 : 32'h0) ^ o;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sig_q <= 32'hFFFFFFFF;
      else        sig_q <= sig_d;
   end

   assign sig = sig_q;
`else
   assign sig = 32'h00000000;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed self-checking bench for alu_result_capture (DEPTH=8); the signature
// expectation follows ALU_CAP_SIGNATURE_EN.
module tb_alu_result_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        cap_valid;
   logic        cap_ready;
   logic [3:0]  op;
   logic [15:0] i0, i1;
   logic [31:0] o;
   logic        overflow, cout;
   logic        rd_valid;
   logic        rd_ready;
   logic [69:0] rd_data;
   logic [3:0]  count;
   logic [7:0]  drop_cnt;
   logic [31:0] sig;

   int vectors     = 0;
   int miscompares = 0;

   alu_result_capture #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_ready(cap_ready),
      .op(op), .i0(i0), .i1(i1), .o(o), .overflow(overflow), .cout(cout),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .drop_cnt(drop_cnt), .sig(sig)
   );

   always #5 clk = ~clk;

`ifdef ALU_CAP_SIGNATURE_EN
   localparam logic [31:0] SIG_SEED  = 32'hFFFFFFFF;
   localparam logic [31:0] SIG_FIRST = 32'hFB3EE9F1;
`else
   localparam logic [31:0] SIG_SEED  = 32'h00000000;
   localparam logic [31:0] SIG_FIRST = 32'h00000000;
`endif

   localparam logic [69:0] FIRST_REC = {4'h0, 16'h03E8, 16'h07D0, 32'h00000BB8, 1'b0, 1'b0};

   function automatic logic [69:0] mkRec(input int t);
      logic [15:0] a;
      logic [15:0] b;
      a = 16'h1000 + 16'(t);
      b = ~a;
      return {4'(t), a, b, {a, b} ^ 32'h00FF00FF, t[0], t[1]};
   endfunction

   task automatic applyStimulus(input logic v, input logic [69:0] rec, input logic rdy);
      cap_valid = v;
      {op, i0, i1, o, overflow, cout} = rec;
      rd_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [69:0] observed,
                              input logic [69:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int next_tag;
      int pop_tag;

      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
      #12.5;
      reset = 1'b1;
      #0.5;
      checkOutput("reset_count", 70'(count), 70'(0));
      checkOutput("reset_rd_valid", 70'(rd_valid), 70'(0));
      checkOutput("reset_cap_ready", 70'(cap_ready), 70'(1));
      checkOutput("reset_drop_cnt", 70'(drop_cnt), 70'(0));
      checkOutput("reset_sig", 70'(sig), 70'(SIG_SEED));

      step();
      applyStimulus(1'b1, FIRST_REC, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("first_rd_valid", 70'(rd_valid), 70'(1));
      checkOutput("first_rd_data", rd_data, FIRST_REC);
      checkOutput("first_count", 70'(count), 70'(1));
      checkOutput("first_sig", 70'(sig), 70'(SIG_FIRST));
      applyStimulus(1'b0, '0, 1'b1);
      step();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("first_pop_count", 70'(count), 70'(0));
      checkOutput("first_pop_rd_valid", 70'(rd_valid), 70'(0));

      for (int t = 0; t < 11; t++) begin
         applyStimulus(1'b1, mkRec(t), 1'b0);
         step();
      end
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("full_count", 70'(count), 70'(8));
      checkOutput("full_cap_ready", 70'(cap_ready), 70'(0));
      checkOutput("full_drop_cnt", 70'(drop_cnt), 70'(3));

      // The refused request on a full FIFO must not be accepted even with a pop.
      applyStimulus(1'b1, mkRec(15), 1'b1);
      checkOutput("full_pop_head", rd_data, mkRec(0));
      step();
      checkOutput("full_pop_count", 70'(count), 70'(7));
      checkOutput("full_pop_drop_cnt", 70'(drop_cnt), 70'(4));
      applyStimulus(1'b0, '0, 1'b1);
      for (int t = 1; t < 8; t++) begin
         checkOutput($sformatf("drain_rec%0d", t), rd_data, mkRec(t));
         step();
      end
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("drain_count", 70'(count), 70'(0));
      checkOutput("drain_rd_valid", 70'(rd_valid), 70'(0));

      next_tag = 0;
      pop_tag  = 0;
      for (int t = 0; t < 4; t++) begin
         applyStimulus(1'b1, mkRec(next_tag), 1'b0);
         step();
         next_tag++;
      end
      checkOutput("fill4_count", 70'(count), 70'(4));
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, mkRec(next_tag), 1'b1);
         checkOutput($sformatf("stream_head%0d", k), rd_data, mkRec(pop_tag));
         step();
         next_tag++;
         pop_tag++;
         checkOutput($sformatf("stream_count%0d", k), 70'(count), 70'(4));
      end

      applyStimulus(1'b1, mkRec(next_tag), 1'b0);
      step();
      next_tag++;
      checkOutput("pre_reset_count", 70'(count), 70'(5));
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("pre_reset_head", rd_data, mkRec(pop_tag));
      #3;
      reset = 1'b0;
      #1;
      checkOutput("midreset_count", 70'(count), 70'(0));
      checkOutput("midreset_rd_valid", 70'(rd_valid), 70'(0));
      checkOutput("midreset_cap_ready", 70'(cap_ready), 70'(1));
      checkOutput("midreset_drop_cnt", 70'(drop_cnt), 70'(0));
      checkOutput("midreset_sig", 70'(sig), 70'(SIG_SEED));
      applyStimulus(1'b0, '0, 1'b0);
      step();
      reset = 1'b1;
      #1;
      applyStimulus(1'b1, FIRST_REC, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("post_reset_count", 70'(count), 70'(1));
      checkOutput("post_reset_rd_data", rd_data, FIRST_REC);
      checkOutput("post_reset_sig", 70'(sig), 70'(SIG_FIRST));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
